// File: rtl/game_pkg.sv
// Shared game types and sprite geometry, used by game_ctrl, render and the
// player/enemy position blocks.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      HIT  = 2'd2,
      OVER = 2'd3
   } game_state_t;

   localparam int SCORE_MAX    = 15;
   localparam int PLAYER_W_DEF = 32;
   localparam int PLAYER_H_DEF = 32;
   localparam int ENEMY_W_DEF  = 32;
   localparam int ENEMY_H_DEF  = 32;

   // Widen a coordinate by one bit before adding a sprite size so the far
   // edge never wraps around at the top of the 16-bit range.
   function automatic logic [16:0] far_edge(input logic [15:0] pos, input int unsigned size);
      return {1'b0, pos} + 17'(size);
   endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous level, followed by a single-cycle
// pulse on each synchronized rising edge.
module sync_rise (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Pulse is valid the cycle after the second flop captures the level,
   // so the controller sees a state change three clocks after the input rises.
   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: collision compare, play/hit/over FSM, score and
// lives bookkeeping driven by the synchronized ms tick and start button.
module game_ctrl
   import game_pkg::*;
#(
   parameter int PLAYER_W    = PLAYER_W_DEF,
   parameter int PLAYER_H    = PLAYER_H_DEF,
   parameter int ENEMY_W     = ENEMY_W_DEF,
   parameter int ENEMY_H     = ENEMY_H_DEF,
   parameter int LIVES       = 3,
   parameter int SCORE_TICKS = 1000,
   parameter int HIT_TICKS   = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_in,
   input  logic        button,
   input  logic [15:0] x_player,
   input  logic [15:0] y_player,
   input  logic [15:0] x_enemy,
   input  logic [15:0] y_enemy,
   output logic [1:0]  game_state,
   output logic [3:0]  score,
   output logic [1:0]  lives,
   output logic        player_dead,
   output logic        led
);

   localparam int TCW = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
   localparam int HCW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

   localparam logic [TCW-1:0] TICK_LAST  = TCW'(SCORE_TICKS - 1);
   localparam logic [HCW-1:0] HIT_LAST   = HCW'(HIT_TICKS - 1);
   localparam logic [1:0]     LIVES_INIT = 2'(LIVES);
   localparam logic [3:0]     SCORE_TOP  = 4'(SCORE_MAX);

   logic tick_s;
   logic start_s;
   logic hit_s;

   game_state_t    state_q;
   logic [3:0]     score_q;
   logic [1:0]     lives_q;
   logic           player_dead_q;
   logic [TCW-1:0] tick_cnt_q;
   logic [HCW-1:0] hit_cnt_q;

   sync_rise u_tick_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (tick_in),
      .rise_o  (tick_s)
   );

   sync_rise u_start_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (button),
      .rise_o  (start_s)
   );

   // Strict compares: sprites whose edges only touch do not collide.
   assign hit_s = ({1'b0, x_player} < far_edge(x_enemy, ENEMY_W))
                & ({1'b0, x_enemy}  < far_edge(x_player, PLAYER_W))
                & ({1'b0, y_player} < far_edge(y_enemy, ENEMY_H))
                & ({1'b0, y_enemy}  < far_edge(y_player, PLAYER_H));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         score_q       <= 4'd0;
         lives_q       <= LIVES_INIT;
         player_dead_q <= 1'b0;
         tick_cnt_q    <= '0;
         hit_cnt_q     <= '0;
      end else begin
         player_dead_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_s) begin
                  state_q    <= PLAY;
                  score_q    <= 4'd0;
                  lives_q    <= LIVES_INIT;
                  tick_cnt_q <= '0;
               end
            end
            PLAY: begin
               // A hit on the rollover tick takes priority over the score point.
               if (tick_s) begin
                  if (hit_s) begin
                     state_q       <= HIT;
                     lives_q       <= lives_q - 2'd1;
                     player_dead_q <= 1'b1;
                     hit_cnt_q     <= '0;
                     tick_cnt_q    <= '0;
                  end else if (tick_cnt_q == TICK_LAST) begin
                     tick_cnt_q <= '0;
                     if (score_q != SCORE_TOP) begin
                        score_q <= score_q + 4'd1;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + TCW'(1);
                  end
               end
            end
            HIT: begin
               if (tick_s) begin
                  if (hit_cnt_q == HIT_LAST) begin
                     hit_cnt_q  <= '0;
                     tick_cnt_q <= '0;
                     state_q    <= (lives_q == 2'd0) ? OVER : PLAY;
                  end else begin
                     hit_cnt_q <= hit_cnt_q + HCW'(1);
                  end
               end
            end
            OVER: begin
               if (start_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign game_state  = state_q;
   assign score       = score_q;
   assign lives       = lives_q;
   assign player_dead = player_dead_q;
   assign led         = (state_q == OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expected output tuples are queued as stimulus
// is applied and popped for comparison once the DUT has had time to respond.
module tb_game_ctrl;
   import game_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick_in;
   logic        button;
   logic [15:0] x_player, y_player, x_enemy, y_enemy;
   logic [1:0]  game_state;
   logic [3:0]  score;
   logic [1:0]  lives;
   logic        player_dead;
   logic        led;

   int n_tests  = 0;
   int n_fail   = 0;
   int dead_cnt = 0;

   typedef struct {
      string      name;
      logic [8:0] v;
   } exp_t;

   exp_t exp_q[$];

   game_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .tick_in     (tick_in),
      .button      (button),
      .x_player    (x_player),
      .y_player    (y_player),
      .x_enemy     (x_enemy),
      .y_enemy     (y_enemy),
      .game_state  (game_state),
      .score       (score),
      .lives       (lives),
      .player_dead (player_dead),
      .led         (led)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (player_dead === 1'b1) dead_cnt++;
   end

   function automatic logic [8:0] obs();
      return {game_state, score, lives, led};
   endfunction

   task automatic push_exp(input string n, input game_state_t st, input int sc, input int lv, input logic ld);
      exp_t e;
      e.name = n;
      e.v    = {st, 4'(sc), 2'(lv), ld};
      exp_q.push_back(e);
   endtask

   task automatic set_pos(input int xp, input int yp, input int xe, input int ye);
      x_player = 16'(xp);
      y_player = 16'(yp);
      x_enemy  = 16'(xe);
      y_enemy  = 16'(ye);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_in = 1'b1;
         repeat (3) @(negedge clk);
         tick_in = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic press();
      button = 1'b1;
      repeat (3) @(negedge clk);
      button = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1; tick_in = 1'b0; button = 1'b0;
      set_pos(100, 100, 400, 300);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      push_exp("reset_state", IDLE, 0, 3, 1'b0);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v || player_dead !== 1'b0) begin
         n_fail++; $display("FAIL %s: got %h dead=%b required %h dead=0", e.name, obs(), player_dead, e.v);
      end
   endtask

   task automatic test_start();
      exp_t e;
      button = 1'b1;
      push_exp("start_lat2", IDLE, 0, 3, 1'b0);
      repeat (2) @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      push_exp("start_lat3", PLAY, 0, 3, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      button = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_score();
      exp_t e;
      push_exp("score_999", PLAY, 0, 3, 1'b0);
      do_ticks(999);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      push_exp("score_1000", PLAY, 1, 3, 1'b0);
      do_ticks(1);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      push_exp("score_2000", PLAY, 2, 3, 1'b0);
      do_ticks(1000);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
   endtask

   task automatic test_collision();
      exp_t e;
      int d0;
      set_pos(100, 100, 120, 110);
      d0 = dead_cnt;
      push_exp("hit_enter", HIT, 2, 2, 1'b0);
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v || player_dead !== 1'b1) begin
         n_fail++; $display("FAIL %s: got %h dead=%b required %h dead=1", e.name, obs(), player_dead, e.v);
      end
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (dead_cnt - d0 != 1) begin
         n_fail++; $display("FAIL dead_pulse_len: got %0d cycles required 1", dead_cnt - d0);
      end
      push_exp("hit_hold_499", HIT, 2, 2, 1'b0);
      do_ticks(499);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      set_pos(100, 100, 132, 110);
      push_exp("hit_exit_500", PLAY, 2, 2, 1'b0);
      do_ticks(1);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
   endtask

   task automatic test_edge_touch();
      exp_t e;
      int d0;
      d0 = dead_cnt;
      set_pos(100, 100, 132, 110);
      do_ticks(100);
      set_pos(100, 100, 120, 132);
      do_ticks(10);
      set_pos(100, 100, 68, 68);
      push_exp("edge_touch", PLAY, 2, 2, 1'b0);
      do_ticks(10);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v || dead_cnt != d0) begin
         n_fail++; $display("FAIL %s: got %h deaths=%0d required %h deaths=0", e.name, obs(), dead_cnt - d0, e.v);
      end
   endtask

   task automatic test_game_over();
      exp_t e;
      int trans;
      logic [1:0] prev;
      set_pos(100, 100, 120, 110);
      push_exp("second_hit", HIT, 2, 1, 1'b0);
      do_ticks(1);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      do_ticks(500);
      push_exp("third_hit", HIT, 2, 0, 1'b0);
      do_ticks(1);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      push_exp("over", OVER, 2, 0, 1'b1);
      do_ticks(500);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      // Button held for about 10 ms worth of clocks must leave OVER exactly once.
      trans = 0;
      prev  = game_state;
      button = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (game_state !== prev) trans++;
         prev = game_state;
      end
      button = 1'b0;
      repeat (3) @(negedge clk);
      push_exp("held_button_idle", IDLE, 2, 0, 1'b0);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v || trans != 1) begin
         n_fail++; $display("FAIL %s: got %h transitions=%0d required %h transitions=1", e.name, obs(), trans, e.v);
      end
      set_pos(100, 100, 400, 300);
      push_exp("restart", PLAY, 0, 3, 1'b0);
      press();
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      push_exp("pre_rollover", PLAY, 0, 3, 1'b0);
      do_ticks(999);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      set_pos(100, 100, 120, 110);
      push_exp("hit_beats_score", HIT, 0, 2, 1'b0);
      do_ticks(1);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
   endtask

   task automatic test_reset_mid_play();
      exp_t e;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      set_pos(100, 100, 400, 300);
      @(negedge clk);
      // Start and tick rise together: the tick must not be counted.
      button = 1'b1; tick_in = 1'b1;
      repeat (3) @(negedge clk);
      button = 1'b0; tick_in = 1'b0;
      repeat (3) @(negedge clk);
      push_exp("start_tick_uncounted", PLAY, 0, 3, 1'b0);
      do_ticks(999);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      push_exp("score_five", PLAY, 5, 3, 1'b0);
      do_ticks(4001);
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v) begin
         n_fail++; $display("FAIL %s: got %h required %h", e.name, obs(), e.v);
      end
      #2 reset = 1'b1;
      push_exp("async_reset", IDLE, 0, 3, 1'b0);
      #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs() !== e.v || player_dead !== 1'b0) begin
         n_fail++; $display("FAIL %s: got %h dead=%b required %h dead=0", e.name, obs(), player_dead, e.v);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_start();
      test_score();
      test_collision();
      test_edge_touch();
      test_game_over();
      test_simultaneous();
      test_reset_mid_play();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
